// File: rtl/mock_cu.sv
// Mock bus-and-tag control unit: passes the channel from its B side through to the
// A side and answers selection at CU_ADDRESS. Define MOCK_CU_PARITY_CHECK_EN to check bus-out parity.
module mock_cu #(
  parameter logic [7:0] CU_ADDRESS = 8'hF0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  b_bus_out,
  input  logic        b_bus_out_parity,
  input  logic        b_operational_out,
  input  logic        b_hold_out,
  input  logic        b_select_out,
  input  logic        b_address_out,
  input  logic        b_command_out,
  input  logic        b_service_out,
  input  logic        b_suppress_out,
  output logic [7:0]  b_bus_in,
  output logic        b_bus_in_parity,
  output logic        b_operational_in,
  output logic        b_request_in,
  output logic        b_select_in,
  output logic        b_address_in,
  output logic        b_status_in,
  output logic        b_service_in,
  output logic [7:0]  a_bus_out,
  output logic        a_bus_out_parity,
  output logic        a_operational_out,
  output logic        a_hold_out,
  output logic        a_select_out,
  output logic        a_address_out,
  output logic        a_command_out,
  output logic        a_service_out,
  output logic        a_suppress_out,
  input  logic [7:0]  a_bus_in,
  input  logic        a_bus_in_parity,
  input  logic        a_operational_in,
  input  logic        a_request_in,
  input  logic        a_select_in,
  input  logic        a_address_in,
  input  logic        a_status_in,
  input  logic        a_service_in,
  input  logic        mock_busy,
  input  logic        mock_short_busy,
  input  logic [15:0] mock_limit,
  output logic [7:0]  command,
  output logic [15:0] count
);

  typedef enum logic [2:0] {
    IDLE, SHORT_BUSY, ADDR_IN, WAIT_CMD, INIT_STATUS, DATA, END_STATUS, WAIT_DESEL
  } state_t;

  state_t      state;
  logic        captured;
  logic        own_opl, own_addr, own_sta, own_srv;
  logic [7:0]  own_bus;
  logic        cmd_seen;
  logic        hs_wait;
  logic        par_err;
  logic        unused_in;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic is_in_cmd(input logic [7:0] c);
    return (c[1:0] == 2'b10) || (c[3:0] == 4'h4);
  endfunction

  function automatic logic bus_par_bad(input logic [7:0] d, input logic p);
`ifdef MOCK_CU_PARITY_CHECK_EN
    return p != odd_par(d);
`else
    return 1'b0 & p & d[0];
`endif
  endfunction

  assign a_bus_out         = b_bus_out;
  assign a_bus_out_parity  = b_bus_out_parity;
  assign a_operational_out = b_operational_out;
  assign a_hold_out        = b_hold_out;
  assign a_select_out      = b_select_out & ~captured;
  assign a_address_out     = b_address_out;
  assign a_command_out     = b_command_out;
  assign a_service_out     = b_service_out;
  assign a_suppress_out    = b_suppress_out;

  // Inbound: own registered tags merged with whatever the downstream units drive
  assign b_bus_in         = own_bus | a_bus_in;
  assign b_bus_in_parity  = odd_par(b_bus_in);
  assign b_operational_in = own_opl | a_operational_in;
  assign b_address_in     = own_addr | a_address_in;
  assign b_status_in      = own_sta | a_status_in;
  assign b_service_in     = own_srv | a_service_in;
  assign b_select_in      = a_select_in;
  assign b_request_in     = a_request_in;
  assign unused_in        = a_bus_in_parity;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      captured <= 1'b0;
      own_opl  <= 1'b0;
      own_addr <= 1'b0;
      own_sta  <= 1'b0;
      own_srv  <= 1'b0;
      own_bus  <= 8'h00;
      command  <= 8'h00;
      count    <= 16'h0000;
      cmd_seen <= 1'b0;
      hs_wait  <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      if (!b_select_out) captured <= 1'b0;
      if (!b_operational_out) begin
        own_opl  <= 1'b0;
        own_addr <= 1'b0;
        own_sta  <= 1'b0;
        own_srv  <= 1'b0;
        own_bus  <= 8'h00;
        cmd_seen <= 1'b0;
        hs_wait  <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (b_select_out && b_hold_out && b_address_out && b_bus_out == CU_ADDRESS) begin
              captured <= 1'b1;
              par_err  <= 1'b0;
              if (mock_short_busy) begin
                own_sta <= 1'b1;
                own_bus <= 8'h50;
                state   <= SHORT_BUSY;
              end else begin
                own_opl  <= 1'b1;
                own_addr <= 1'b1;
                own_bus  <= CU_ADDRESS;
                state    <= ADDR_IN;
              end
            end
          end
          SHORT_BUSY: begin
            if (!b_select_out) begin
              own_sta <= 1'b0;
              own_bus <= 8'h00;
              state   <= IDLE;
            end
          end
          ADDR_IN: begin
            if (!b_address_out) begin
              own_addr <= 1'b0;
              own_bus  <= 8'h00;
              state    <= WAIT_CMD;
            end
          end
          WAIT_CMD: begin
            if (!cmd_seen) begin
              if (b_command_out) begin
                command  <= b_bus_out;
                count    <= 16'h0000;
                cmd_seen <= 1'b1;
                par_err  <= bus_par_bad(b_bus_out, b_bus_out_parity);
              end
            end else if (!b_command_out) begin
              cmd_seen <= 1'b0;
              if (par_err) begin
                hs_wait <= 1'b1;
                state   <= END_STATUS;
              end else begin
                own_sta <= 1'b1;
                own_bus <= mock_busy ? 8'h10 : 8'h00;
                state   <= INIT_STATUS;
              end
            end
          end
          INIT_STATUS: begin
            if (b_service_out) begin
              own_sta <= 1'b0;
              own_bus <= 8'h00;
              if (mock_busy) begin
                own_opl <= 1'b0;
                state   <= WAIT_DESEL;
              end else begin
                hs_wait <= 1'b1;
                state   <= (command == 8'h00 || command[1:0] == 2'b11) ? END_STATUS : DATA;
              end
            end else if (b_command_out) begin
              own_sta <= 1'b0;
              own_opl <= 1'b0;
              own_bus <= 8'h00;
              state   <= WAIT_DESEL;
            end
          end
          // hs_wait holds off the next tag until the channel's previous reply has dropped
          DATA: begin
            if (hs_wait) begin
              if (!b_service_out && !b_command_out) hs_wait <= 1'b0;
            end else if (!own_srv) begin
              if (count == mock_limit || par_err) begin
                hs_wait <= 1'b1;
                state   <= END_STATUS;
              end else begin
                own_srv <= 1'b1;
                own_bus <= is_in_cmd(command) ? count[7:0] : 8'h00;
              end
            end else if (b_service_out) begin
              count   <= sat_inc(count);
              own_srv <= 1'b0;
              own_bus <= 8'h00;
              hs_wait <= 1'b1;
              if (!is_in_cmd(command)) par_err <= bus_par_bad(b_bus_out, b_bus_out_parity);
            end else if (b_command_out) begin
              own_srv <= 1'b0;
              own_bus <= 8'h00;
              hs_wait <= 1'b1;
              state   <= END_STATUS;
            end
          end
          END_STATUS: begin
            if (hs_wait) begin
              if (!b_service_out && !b_command_out) begin
                hs_wait <= 1'b0;
                own_sta <= 1'b1;
                own_bus <= par_err ? 8'h0E : 8'h0C;
              end
            end else if (b_service_out || b_command_out) begin
              own_sta <= 1'b0;
              own_opl <= 1'b0;
              own_bus <= 8'h00;
              state   <= WAIT_DESEL;
            end
          end
          WAIT_DESEL: begin
            if (!b_select_out && !b_hold_out) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mock_cu.sv
// Directed bench for mock_cu: drives channel sequences from the B side and checks the
// unit's replies, merge and pass-through behaviour against hand-computed values.
module tb_mock_cu;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  b_bus_out;
  logic        b_bus_out_parity;
  logic        b_operational_out, b_hold_out, b_select_out, b_address_out;
  logic        b_command_out, b_service_out, b_suppress_out;
  logic [7:0]  b_bus_in;
  logic        b_bus_in_parity;
  logic        b_operational_in, b_request_in, b_select_in, b_address_in, b_status_in, b_service_in;
  logic [7:0]  a_bus_out;
  logic        a_bus_out_parity;
  logic        a_operational_out, a_hold_out, a_select_out, a_address_out;
  logic        a_command_out, a_service_out, a_suppress_out;
  logic [7:0]  a_bus_in;
  logic        a_bus_in_parity;
  logic        a_operational_in, a_request_in, a_select_in, a_address_in, a_status_in, a_service_in;
  logic        mock_busy, mock_short_busy;
  logic [15:0] mock_limit;
  logic [7:0]  command;
  logic [15:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  mock_cu dut (
    .aclk(aclk), .aresetn(aresetn),
    .b_bus_out(b_bus_out), .b_bus_out_parity(b_bus_out_parity),
    .b_operational_out(b_operational_out), .b_hold_out(b_hold_out),
    .b_select_out(b_select_out), .b_address_out(b_address_out),
    .b_command_out(b_command_out), .b_service_out(b_service_out),
    .b_suppress_out(b_suppress_out),
    .b_bus_in(b_bus_in), .b_bus_in_parity(b_bus_in_parity),
    .b_operational_in(b_operational_in), .b_request_in(b_request_in),
    .b_select_in(b_select_in), .b_address_in(b_address_in),
    .b_status_in(b_status_in), .b_service_in(b_service_in),
    .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
    .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
    .a_select_out(a_select_out), .a_address_out(a_address_out),
    .a_command_out(a_command_out), .a_service_out(a_service_out),
    .a_suppress_out(a_suppress_out),
    .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
    .a_operational_in(a_operational_in), .a_request_in(a_request_in),
    .a_select_in(a_select_in), .a_address_in(a_address_in),
    .a_status_in(a_status_in), .a_service_in(a_service_in),
    .mock_busy(mock_busy), .mock_short_busy(mock_short_busy),
    .mock_limit(mock_limit), .command(command), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tag(input int k);
    case (k)
      0:       return b_operational_in;
      1:       return b_address_in;
      2:       return b_status_in;
      default: return b_service_in;
    endcase
  endfunction

  // Bounded wait on an inbound tag, sampled on falling edges
  task automatic wait_in(input int k, input logic v, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (get_tag(k) == v) break;
    end
    check(tag, {31'b0, get_tag(k)}, {31'b0, v});
  endtask

  task automatic drive_bus(input logic [7:0] d);
    b_bus_out        = d;
    b_bus_out_parity = ~^d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  task automatic select_unit(input logic [7:0] addr);
    b_operational_out = 1'b1;
    b_hold_out        = 1'b1;
    b_select_out      = 1'b1;
    b_address_out     = 1'b1;
    drive_bus(addr);
  endtask

  task automatic addr_and_cmd(input logic [7:0] cmd);
    wait_in(1, 1'b1, "addr_in_up");
    check("addr_byte", {24'b0, b_bus_in}, 32'hF0);
    check("opl_up", {31'b0, b_operational_in}, 32'd1);
    b_address_out = 1'b0;
    drive_bus(8'h00);
    wait_in(1, 1'b0, "addr_in_down");
    b_command_out = 1'b1;
    drive_bus(cmd);
    @(negedge aclk);
    b_command_out = 1'b0;
    drive_bus(8'h00);
  endtask

  task automatic take_status(input logic [7:0] exp, input string tag);
    wait_in(2, 1'b1, tag);
    check(tag, {24'b0, b_bus_in}, {24'b0, exp});
    b_service_out = 1'b1;
    wait_in(2, 1'b0, "status_drop");
    b_service_out = 1'b0;
  endtask

  task automatic data_cycle(input logic [7:0] exp_in, input logic [7:0] wr);
    wait_in(3, 1'b1, "svc_in_up");
    check("svc_bus", {24'b0, b_bus_in}, {24'b0, exp_in});
    b_service_out = 1'b1;
    drive_bus(wr);
    wait_in(3, 1'b0, "svc_in_down");
    b_service_out = 1'b0;
    drive_bus(8'h00);
  endtask

  task automatic deselect();
    b_select_out  = 1'b0;
    b_hold_out    = 1'b0;
    b_address_out = 1'b0;
    drive_bus(8'h00);
    idle_cycles(3);
  endtask

  initial begin
    aresetn = 1'b0;
    b_operational_out = 1'b0; b_hold_out = 1'b0; b_select_out = 1'b0;
    b_address_out = 1'b0; b_command_out = 1'b0; b_service_out = 1'b0; b_suppress_out = 1'b0;
    drive_bus(8'h00);
    a_bus_in = 8'h00; a_bus_in_parity = 1'b1;
    a_operational_in = 1'b0; a_request_in = 1'b0; a_select_in = 1'b0;
    a_address_in = 1'b0; a_status_in = 1'b0; a_service_in = 1'b0;
    mock_busy = 1'b0; mock_short_busy = 1'b0; mock_limit = 16'd3;
    idle_cycles(3);
    check("rst_tags", {28'b0, b_operational_in, b_address_in, b_status_in, b_service_in}, 32'h0);
    check("rst_bus", {23'b0, b_bus_in, b_bus_in_parity}, {23'b0, 8'h00, 1'b1});
    check("rst_regs", {8'b0, command, count}, 32'h0);
    aresetn = 1'b1;
    idle_cycles(2);

    // Write 8'h01, limit 3
    select_unit(8'hF0);
    addr_and_cmd(8'h01);
    check("a_sel_blocked", {31'b0, a_select_out}, 32'd0);
    take_status(8'h00, "init_status");
    data_cycle(8'h00, 8'hA5);
    data_cycle(8'h00, 8'h5A);
    data_cycle(8'h00, 8'h33);
    take_status(8'h0C, "end_status_wr");
    check("opl_down_wr", {31'b0, b_operational_in}, 32'd0);
    deselect();
    check("cmd_wr", {24'b0, command}, 32'h01);
    check("count_wr", {16'b0, count}, 32'd3);

    // Read 8'h02, limit 2
    mock_limit = 16'd2;
    select_unit(8'hF0);
    addr_and_cmd(8'h02);
    take_status(8'h00, "init_status_rd");
    data_cycle(8'h00, 8'h00);
    data_cycle(8'h01, 8'h00);
    take_status(8'h0C, "end_status_rd");
    deselect();
    check("count_rd", {16'b0, count}, 32'd2);

    // Busy
    mock_busy = 1'b1;
    select_unit(8'hF0);
    addr_and_cmd(8'h01);
    wait_in(2, 1'b1, "busy_status_up");
    check("busy_byte", {24'b0, b_bus_in}, 32'h10);
    b_service_out = 1'b1;
    wait_in(0, 1'b0, "busy_opl_down");
    check("busy_sta_down", {31'b0, b_status_in}, 32'd0);
    b_service_out = 1'b0;
    deselect();
    check("busy_count", {16'b0, count}, 32'd0);
    mock_busy = 1'b0;

    // Short busy
    mock_short_busy = 1'b1;
    select_unit(8'hF0);
    wait_in(2, 1'b1, "sbusy_up");
    check("sbusy_byte", {24'b0, b_bus_in}, 32'h50);
    check("sbusy_no_opl", {31'b0, b_operational_in}, 32'd0);
    b_select_out = 1'b0;
    b_hold_out = 1'b0;
    b_address_out = 1'b0;
    drive_bus(8'h00);
    wait_in(2, 1'b0, "sbusy_down");
    deselect();
    mock_short_busy = 1'b0;

    // Foreign address: pass-through only
    select_unit(8'h20);
    idle_cycles(4);
    check("foreign_no_resp", {30'b0, b_operational_in, b_address_in}, 32'd0);
    check("foreign_a_sel", {31'b0, a_select_out}, 32'd1);
    a_address_in = 1'b1;
    a_bus_in = 8'h20;
    #1;
    check("merge_addr", {31'b0, b_address_in}, 32'd1);
    check("merge_bus", {23'b0, b_bus_in, b_bus_in_parity}, {23'b0, 8'h20, 1'b0});
    a_address_in = 1'b0;
    a_bus_in = 8'h00;
    deselect();

    // Stop by command out on 2nd service in, limit 5
    mock_limit = 16'd5;
    select_unit(8'hF0);
    addr_and_cmd(8'h01);
    take_status(8'h00, "init_status_stop");
    data_cycle(8'h00, 8'h11);
    wait_in(3, 1'b1, "stop_svc_up");
    b_command_out = 1'b1;
    wait_in(3, 1'b0, "stop_svc_down");
    b_command_out = 1'b0;
    take_status(8'h0C, "end_status_stop");
    deselect();
    check("count_stop", {16'b0, count}, 32'd1);

    // Operational out dropped mid-data
    select_unit(8'hF0);
    addr_and_cmd(8'h02);
    take_status(8'h00, "init_status_opl");
    wait_in(3, 1'b1, "opl_svc_up");
    b_operational_out = 1'b0;
    @(negedge aclk);
    check("opl_drop_tags", {28'b0, b_operational_in, b_address_in, b_status_in, b_service_in}, 32'h0);
    check("opl_drop_bus", {24'b0, b_bus_in}, 32'h0);
    deselect();
    check("opl_keep_regs", {8'b0, command, count}, {8'b0, 8'h02, 16'h0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
